systolic_array_nxn: RTL

Parametrised N×N output-stationary systolic matrix multiplier computing C = A·B for square N×N operand matrices. Generalises the fixed 3×3 array: internal operand skewing, a valid/ready load handshake, a flush counter, and a held result with output handshake replace externally skewed feeding and a bare `done`. It sits between the operand buffers and the result writeback in the TPU datapath.

---
 rtl/systolic_pkg.sv | 21 ++
 rtl/systolic_pe.sv | 52 +++++
 rtl/systolic_array_nxn.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/systolic_pkg.sv
// Shared types and sizing helpers for the N x N output-stationary systolic multiplier.
package systolic_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Width of the beat and flush counters; both count below 2N.
  function automatic int unsigned cnt_w(input int unsigned n);
    return $clog2(2 * n);
  endfunction

  // Enabled cycles needed to drain the skewed wavefront after the last beat.
  function automatic int unsigned flush_len(input int unsigned n);
    return 2 * n - 1;
  endfunction

endpackage

// File: rtl/systolic_pe.sv
// One MAC cell: registers a rightward and b downward, accumulates a*b on enable.
// SYSTOLIC_SIGNED_EN selects two's-complement operands and sign-extended products.
module systolic_pe #(
  parameter int unsigned DW    = 8,
  parameter int unsigned ACC_W = 20
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic             i_clr,
  input  logic [DW-1:0]    i_a,
  input  logic [DW-1:0]    i_b,
  output logic [DW-1:0]    o_a,
  output logic [DW-1:0]    o_b,
  output logic [ACC_W-1:0] o_acc
);

  localparam int unsigned PW = 2 * DW;

`ifdef SYSTOLIC_SIGNED_EN
  logic signed [PW-1:0] w_prod;
  assign w_prod = PW'($signed(i_a)) * PW'($signed(i_b));
`else
  logic [PW-1:0] w_prod;
  assign w_prod = PW'(i_a) * PW'(i_b);
`endif

  logic [ACC_W-1:0] w_prod_ext;
  assign w_prod_ext = ACC_W'(w_prod);

  logic [DW-1:0]    r_a;
  logic [DW-1:0]    r_b;
  logic [ACC_W-1:0] r_acc;

  // Clear restarts the sum with this cycle's product so the first beat is not lost.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a   <= '0;
      r_b   <= '0;
      r_acc <= '0;
    end else if (i_en) begin
      r_a   <= i_a;
      r_b   <= i_b;
      r_acc <= (i_clr ? '0 : r_acc) + w_prod_ext;
    end
  end

  assign o_a   = r_a;
  assign o_b   = r_b;
  assign o_acc = r_acc;

endmodule

// File: rtl/systolic_array_nxn.sv
// N x N output-stationary systolic multiplier C = A*B with internal skew and load/result handshakes.
// SYSTOLIC_SIGNED_EN (in systolic_pe) switches operands and results to two's-complement.
module systolic_array_nxn
  import systolic_pkg::*;
#(
  parameter int unsigned N     = 3,
  parameter int unsigned DW    = 8,
  parameter int unsigned ACC_W = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [N*DW-1:0]        a_col,
  input  logic [N*DW-1:0]        b_row,
  output logic                   busy,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [N*N*ACC_W-1:0]   z
);

  localparam int unsigned CNT_W     = cnt_w(N);
  localparam int unsigned FLUSH_LEN = flush_len(N);

  state_e           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_beat_cnt, w_beat_nxt;
  logic [CNT_W-1:0] r_flush_cnt, w_flush_nxt;
  logic             r_in_ready, w_in_ready_nxt;
  logic             r_busy, w_busy_nxt;
  logic             r_out_valid, w_out_valid_nxt;

  logic w_accept;
  logic w_en;
  logic w_clr;

  assign w_accept = in_valid & r_in_ready;
  assign w_en     = w_accept | (r_state == ST_FLUSH);
  assign w_clr    = w_accept & (r_state == ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_beat_cnt  <= '0;
      r_flush_cnt <= '0;
      r_in_ready  <= 1'b0;
      r_busy      <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_beat_cnt  <= w_beat_nxt;
      r_flush_cnt <= w_flush_nxt;
      r_in_ready  <= w_in_ready_nxt;
      r_busy      <= w_busy_nxt;
      r_out_valid <= w_out_valid_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_beat_nxt      = r_beat_cnt;
    w_flush_nxt     = r_flush_cnt;
    w_in_ready_nxt  = 1'b0;
    w_busy_nxt      = 1'b0;
    w_out_valid_nxt = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_beat_nxt  = CNT_W'(1);
          w_state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (w_accept) begin
          if (r_beat_cnt == CNT_W'(N - 1)) begin
            w_beat_nxt  = '0;
            w_state_nxt = ST_FLUSH;
          end else begin
            w_beat_nxt = r_beat_cnt + CNT_W'(1);
          end
        end
      end
      ST_FLUSH: begin
        if (r_flush_cnt == CNT_W'(FLUSH_LEN - 1)) begin
          w_flush_nxt = '0;
          w_state_nxt = ST_DONE;
        end else begin
          w_flush_nxt = r_flush_cnt + CNT_W'(1);
        end
      end
      ST_DONE: begin
        if (r_out_valid & out_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    // Returning from DONE keeps in_ready low one extra cycle: no result/beat overlap.
    w_in_ready_nxt  = (w_state_nxt == ST_LOAD) ||
                      ((w_state_nxt == ST_IDLE) && (r_state == ST_IDLE));
    w_busy_nxt      = (w_state_nxt == ST_LOAD) || (w_state_nxt == ST_FLUSH);
    w_out_valid_nxt = (w_state_nxt == ST_DONE);
  end

  assign in_ready  = r_in_ready;
  assign busy      = r_busy;
  assign out_valid = r_out_valid;

  // Zeros enter the array whenever no beat is being accepted (FLUSH).
  logic [DW-1:0] w_a_inj [N];
  logic [DW-1:0] w_b_inj [N];
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_a_inj[i] = w_accept ? a_col[i*DW +: DW] : '0;
      w_b_inj[i] = w_accept ? b_row[i*DW +: DW] : '0;
    end
  end

  logic [DW-1:0] w_a_edge [N];
  logic [DW-1:0] w_b_edge [N];

  for (genvar gi = 0; gi < N; gi++) begin : g_skew
    if (gi == 0) begin : g_direct
      assign w_a_edge[gi] = w_a_inj[gi];
      assign w_b_edge[gi] = w_b_inj[gi];
    end else begin : g_delay
      logic [DW-1:0] r_a_line [gi];
      logic [DW-1:0] r_b_line [gi];
      always_ff @(posedge clk) begin
        if (rst) begin
          for (int m = 0; m < gi; m++) begin
            r_a_line[m] <= '0;
            r_b_line[m] <= '0;
          end
        end else if (w_en) begin
          r_a_line[0] <= w_a_inj[gi];
          r_b_line[0] <= w_b_inj[gi];
          for (int m = 1; m < gi; m++) begin
            r_a_line[m] <= w_clr ? '0 : r_a_line[m-1];
            r_b_line[m] <= w_clr ? '0 : r_b_line[m-1];
          end
        end
      end
      assign w_a_edge[gi] = w_clr ? '0 : r_a_line[gi-1];
      assign w_b_edge[gi] = w_clr ? '0 : r_b_line[gi-1];
    end
  end

  logic [DW-1:0] w_a_out [N][N];
  logic [DW-1:0] w_b_out [N][N];

  // Stale pipe contents are masked on the clearing edge so only beat 0 contributes.
  for (genvar gi = 0; gi < N; gi++) begin : g_row
    for (genvar gj = 0; gj < N; gj++) begin : g_col
      logic [DW-1:0] w_a_in;
      logic [DW-1:0] w_b_in;
      if (gj == 0) begin : g_a_edge
        assign w_a_in = w_a_edge[gi];
      end else begin : g_a_pipe
        assign w_a_in = w_clr ? '0 : w_a_out[gi][gj-1];
      end
      if (gi == 0) begin : g_b_edge
        assign w_b_in = w_b_edge[gj];
      end else begin : g_b_pipe
        assign w_b_in = w_clr ? '0 : w_b_out[gi-1][gj];
      end
      systolic_pe #(
        .DW    (DW),
        .ACC_W (ACC_W)
      ) u_pe (
        .clk   (clk),
        .rst   (rst),
        .i_en  (w_en),
        .i_clr (w_clr),
        .i_a   (w_a_in),
        .i_b   (w_b_in),
        .o_a   (w_a_out[gi][gj]),
        .o_b   (w_b_out[gi][gj]),
        .o_acc (z[(gi*N+gj)*ACC_W +: ACC_W])
      );
    end
  end

endmodule
